// File: rtl/pattern_det_pkg.sv
// Shared types and default widths for the configurable pattern detector.
package pattern_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam int FRM_W_DEF = 16;

endpackage

// File: rtl/pattern_shift_match.sv
// Serial shift register with fill tracking and length-masked pattern compare.
module pattern_shift_match #(
    parameter int PAT_W = 4,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             xfer,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             hit
);

    logic [PAT_W-1:0] shreg;
    logic [PAT_W-1:0] shifted;
    logic [PAT_W-1:0] mask;
    logic [LEN_W-1:0] fill;
    logic [LEN_W-1:0] fill_next;

    always_comb begin
        shifted   = {shreg[PAT_W-2:0], din};
        fill_next = (fill >= LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : fill + LEN_W'(1);
        mask      = '0;
        for (int unsigned i = 0; i < PAT_W; i++) begin
            mask[i] = (i < 32'(len));
        end
        hit = xfer && (fill_next >= len) && (((shifted ^ pattern) & mask) == '0);
    end

    // Without overlap a match empties the window so the next match needs len fresh bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            fill  <= '0;
        end else if (clear) begin
            shreg <= '0;
            fill  <= '0;
        end else if (xfer) begin
            shreg <= shifted;
            fill  <= (hit && !overlap) ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/pattern_det_ctrl.sv
// Frame sequencer around pattern_shift_match: config shadows, bit/match counters,
// IDLE/RUN/DONE control and registered match pulse.
module pattern_det_ctrl
    import pattern_det_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int FRM_W = FRM_W_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [PAT_W-1:0]           cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
    input  logic                       cfg_overlap,
    input  logic [FRM_W-1:0]           cfg_frame_len,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       din_valid,
    input  logic                       din,
    output logic                       din_ready,
    output logic                       match,
    output logic [CNT_W-1:0]           match_count,
    output logic                       busy,
    output logic                       done
);

    localparam int LEN_W = $clog2(PAT_W + 1);

    state_t           state;
    state_t           state_next;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_eff;
    logic             ovl_q;
    logic [FRM_W-1:0] frame_q;
    logic [FRM_W-1:0] bit_cnt;
    logic             start_acc;
    logic             xfer;
    logic             hit;

    always_comb begin
        state_next = state;
        din_ready  = 1'b0;
        xfer       = 1'b0;
        start_acc  = 1'b0;
        busy       = (state == ST_RUN);
        done       = (state == ST_DONE);
        len_eff    = (cfg_len == '0 || cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : cfg_len;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_acc  = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                din_ready = !stop;
                xfer      = din_valid && !stop;
                if (stop) begin
                    state_next = ST_DONE;
                end else if (xfer && frame_q != '0 && (bit_cnt + FRM_W'(1)) == frame_q) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    pattern_shift_match #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_match (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start_acc),
        .xfer    (xfer),
        .din     (din),
        .pattern (pat_q),
        .len     (len_q),
        .overlap (ovl_q),
        .hit     (hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            ovl_q       <= 1'b0;
            frame_q     <= '0;
            bit_cnt     <= '0;
            match_count <= '0;
            match       <= 1'b0;
        end else begin
            state <= state_next;
            match <= hit;
            if (start_acc) begin
                pat_q       <= cfg_pattern;
                len_q       <= len_eff;
                ovl_q       <= cfg_overlap;
                frame_q     <= cfg_frame_len;
                bit_cnt     <= '0;
                match_count <= '0;
            end else begin
                if (xfer) begin
                    bit_cnt <= bit_cnt + FRM_W'(1);
                end
                if (hit && match_count != '1) begin
                    match_count <= match_count + CNT_W'(1);
                end
            end
        end
    end

endmodule
